bash_hash_stream_if: RTL and testbench
======================================

// Module: bash_hash_stream_if
// PURPOSE
//  Streaming front end for the bash_hash core; replaces AXI/reg_map loading of x/l for bulk data.
//  - Packs XLEN-bit valid/ready input words into NX SLEN-bit lanes and sequences prep/start/first for the core.
//  - Supports multi-block messages, then streams the NY-lane result back out as XLEN-bit words.
// PARAMETERS
//  XLEN  32  stream word width; SLEN % XLEN == 0 required (elaboration error otherwise)
//  SLEN  64  core lane width
//  NX    16  input lanes per block
//  NY    8   output lanes per message
//  (derived) WPL = SLEN/XLEN words per lane; NIN = NX*WPL; NOUT = NY*WPL
// PORTS
//  clk_i      in   1        clock
//  rst_i      in   1        sync reset, active-high
//  s_valid_i  in   1        input word valid
//  s_ready_o  out  1        input word ready
//  s_data_i   in   XLEN     input word
//  s_last_i   in   1        final block of message; sampled only on word NIN-1
//  m_valid_o  out  1        output word valid
//  m_ready_i  in   1        output word ready
//  m_data_o   out  XLEN     output word
//  m_last_o   out  1        final output word (beat NOUT-1)
//  prep_o     out  1        1-cycle pulse to core: load/prepare state
//  start_o    out  1        1-cycle pulse to core: process block in x_o
//  first_o    out  1        high with start_o on first block of a message only
//  rdy_i      in   1        core block-done pulse; honoured only in WAIT
//  x_o        out  NX*SLEN  lane i at [i*SLEN +: SLEN]
//  y_i        in   NY*SLEN  lane j at [(NY-1-j)*SLEN +: SLEN] (lane 0 in MSBs)
//  busy_o     out  1        high in every state except LOAD with word count 0
// BEHAVIOUR
//  - Reset: every output 0, x_o 0, counters 0, state LOAD, message-first flag 1.
//    s_ready_o is 0 during the reset cycle and 1 from the first cycle after.
//  - Packing: accepted word k (0..NIN-1) goes to lane k/WPL; within a lane the first word is most significant.
//    Example: WPL=2 gives x0 = {w0,w1}. Lanes are written in place; x_o holds stable outside LOAD.
//  - States:
//    - LOAD: s_ready_o=1; count increments on s_valid_i&&s_ready_o.
//      On word NIN-1: capture s_last_i; go to PREP if message-first, else START.
//    - PREP: prep_o=1 for one cycle -> START.
//    - START: start_o=1 and first_o=message-first for one cycle; clear message-first -> WAIT.
//    - WAIT: s_ready_o=0; hold until rdy_i=1.
//      If captured last=0 -> LOAD, count=0.
//      If captured last=1 -> capture y_i into output buffer on that edge -> OUT.
//    - OUT: m_valid_o=1; beat b drives lane b/WPL, upper word first.
//      Beat advances on m_valid_o&&m_ready_i; m_last_o=1 on beat NOUT-1.
//      Final handshake -> LOAD, message-first=1, m_valid_o=0 next cycle.
//  - Latency, accept edge of final input word = T:
//    - first block: prep_o at T+1, start_o at T+2;
//    - later blocks: start_o at T+1.
//    - rdy_i high at cycle R: LOAD at R+1 for a non-last block; first m_valid_o at R+1 for a last block.
//  - m_data_o and m_last_o hold stable while m_valid_o && !m_ready_i.
//  - Boundaries:
//    - s_valid_i gaps: no effect on packing.
//    - s_last_i on words other than NIN-1: ignored.
//    - rdy_i outside WAIT: ignored.
//    - rdy_i on the same cycle start_o is high: ignored (WAIT not yet entered).
//    - Input is never accepted during PREP/START/WAIT/OUT.
//    - Reset mid-operation: partial block, pending result and message-first state discarded; full reset values.
//  - Counters are $clog2(NIN) and $clog2(NOUT) bits and wrap to 0 explicitly at terminal count.
// TESTING
//  1) Default params, single-block message:
//     - stimulus: words 0x0..0x1F, s_last_i on word 31; core model raises rdy_i 5 cycles after start;
//       every y lane = 0xAAAA0000_BBBB0000 | lane index.
//     - required: x_o lane0 = 0x00000000_00000001; prep_o at T+1; start_o and first_o at T+2;
//       16 beats, beat0 = 0xAAAA0000, beat1 = 0xBBBB0000, beat15 = 0xBBBB0007 with m_last_o.
//  2) Two-block message, s_last_i only on block 2:
//     -> exactly one prep_o; first_o with start #1 only; no m_valid_o until rdy_i for block 2.
//  3) m_ready_i toggled 1-0-0-1 every 3 cycles -> m_data_o stable while stalled; all 16 beats in order, no duplicates.
//  4) s_valid_i asserted 1 cycle in 3; rdy_i pulsed in LOAD and on the start_o cycle
//     -> packing identical to test 1; stray rdy_i ignored.
//  5) rst_i asserted for 1 cycle in WAIT, then rdy_i pulsed
//     -> all outputs 0; rdy_i ignored; next block issues prep_o again.
//  6) XLEN=64, SLEN=64 (WPL=1) -> 16 input words fill lanes 0..15 one-to-one; 8 output beats, m_last_o on beat 7.

Source files
------------

// File: rtl/bash_hash_stream_if.sv
// rtl/bash_hash_stream_if.sv - streaming word packer and result unpacker for the bash_hash core
// Packs input words into NX lanes, sequences prep/start/first, and streams the NY-lane result back out.
module bash_hash_stream_if #(
  parameter int XLEN = 32,
  parameter int SLEN = 64,
  parameter int NX   = 16,
  parameter int NY   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [XLEN-1:0]      s_data_i,
  input  logic                 s_last_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [XLEN-1:0]      m_data_o,
  output logic                 m_last_o,
  output logic                 prep_o,
  output logic                 start_o,
  output logic                 first_o,
  input  logic                 rdy_i,
  output logic [NX*SLEN-1:0]   x_o,
  input  logic [NY*SLEN-1:0]   y_i,
  output logic                 busy_o
);

  localparam int WPL  = SLEN / XLEN;
  localparam int NIN  = NX * WPL;
  localparam int NOUT = NY * WPL;
  localparam int WCW  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int OCW  = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(NIN - 1);
  localparam logic [OCW-1:0] B_LAST = OCW'(NOUT - 1);

  generate
    if (SLEN % XLEN != 0) begin : g_param_check
      $error("bash_hash_stream_if: SLEN must be a multiple of XLEN");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_LOAD,
    S_PREP,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [OCW-1:0]       bcnt_q, bcnt_d;
  logic                 mfirst_q, mfirst_d;
  logic                 last_q, last_d;
  logic [NX*SLEN-1:0]   x_q, x_d;
  logic [NY*SLEN-1:0]   ybuf_q, ybuf_d;
  logic                 s_fire;
  logic                 m_fire;
  int                   in_off;
  int                   out_off;

  // First word of a lane lands in its most significant slot; output lane 0 sits in the MSBs of y.
  always_comb begin
    in_off  = (int'(wcnt_q) / WPL) * SLEN + (WPL - 1 - (int'(wcnt_q) % WPL)) * XLEN;
    out_off = (NY - 1 - (int'(bcnt_q) / WPL)) * SLEN + (WPL - 1 - (int'(bcnt_q) % WPL)) * XLEN;
  end

  // Handshake and pulse outputs are forced low during the reset cycle itself.
  assign s_ready_o = (state_q == S_LOAD) && !rst_i;
  assign m_valid_o = (state_q == S_OUT) && !rst_i;
  assign prep_o    = (state_q == S_PREP) && !rst_i;
  assign start_o   = (state_q == S_START) && !rst_i;
  assign first_o   = start_o && mfirst_q;
  assign m_last_o  = m_valid_o && (bcnt_q == B_LAST);
  assign m_data_o  = ybuf_q[out_off +: XLEN];
  assign busy_o    = !((state_q == S_LOAD) && (wcnt_q == '0));
  assign x_o       = x_q;
  assign s_fire    = s_valid_i && s_ready_o;
  assign m_fire    = m_valid_o && m_ready_i;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    mfirst_d = mfirst_q;
    last_d   = last_q;
    x_d      = x_q;
    ybuf_d   = ybuf_q;
    case (state_q)
      S_LOAD: begin
        if (s_fire) begin
          x_d[in_off +: XLEN] = s_data_i;
          if (wcnt_q == W_LAST) begin
            wcnt_d  = '0;
            last_d  = s_last_i;
            state_d = mfirst_q ? S_PREP : S_START;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_PREP: begin
        state_d = S_START;
      end
      S_START: begin
        mfirst_d = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_i) begin
          if (last_q) begin
            ybuf_d  = y_i;
            bcnt_d  = '0;
            state_d = S_OUT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_OUT: begin
        if (m_fire) begin
          if (bcnt_q == B_LAST) begin
            bcnt_d   = '0;
            mfirst_d = 1'b1;
            state_d  = S_LOAD;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_LOAD;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      mfirst_q <= 1'b1;
      last_q   <= 1'b0;
      x_q      <= '0;
      ybuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      mfirst_q <= mfirst_d;
      last_q   <= last_d;
      x_q      <= x_d;
      ybuf_q   <= ybuf_d;
    end
  end

endmodule

// File: tb/tb_bash_hash_stream_if.sv
// tb/tb_bash_hash_stream_if.sv - scoreboard bench for bash_hash_stream_if
// Covers default parameters plus a WPL=1 instance.
module tb_bash_hash_stream_if;

  localparam int XLEN = 32;
  localparam int SLEN = 64;
  localparam int NX   = 16;
  localparam int NY   = 8;
  localparam int NIN  = 32;
  localparam int NOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                s_valid, s_ready, s_last;
  logic [XLEN-1:0]     s_data;
  logic                m_valid, m_ready, m_last;
  logic [XLEN-1:0]     m_data;
  logic                prep_o, start_o, first_o, rdy, busy;
  logic [NX*SLEN-1:0]  x_o;
  logic [NY*SLEN-1:0]  y;

  logic                s_valid64, s_ready64, s_last64;
  logic [63:0]         s_data64;
  logic                m_valid64, m_ready64, m_last64;
  logic [63:0]         m_data64;
  logic                prep64, start64, first64, rdy64, busy64;
  logic [16*64-1:0]    x64;
  logic [8*64-1:0]     y64;

  bash_hash_stream_if #(.XLEN(XLEN), .SLEN(SLEN), .NX(NX), .NY(NY)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .prep_o(prep_o), .start_o(start_o), .first_o(first_o), .rdy_i(rdy),
    .x_o(x_o), .y_i(y), .busy_o(busy)
  );

  bash_hash_stream_if #(.XLEN(64), .SLEN(64), .NX(16), .NY(8)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid64), .s_ready_o(s_ready64), .s_data_i(s_data64), .s_last_i(s_last64),
    .m_valid_o(m_valid64), .m_ready_i(m_ready64), .m_data_o(m_data64), .m_last_o(m_last64),
    .prep_o(prep64), .start_o(start64), .first_o(first64), .rdy_i(rdy64),
    .x_o(x64), .y_i(y64), .busy_o(busy64)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] sbq[$];
  logic [63:0] lane_exp[NY];

  int  prep_cnt, start_cnt, first_cnt, prep_cyc, start_cyc, first_mv, last_rdy, cd;
  bit  core_auto, first_on_1, rdy_auto, rdy_man;
  assign rdy = rdy_auto | rdy_man;

  // Core model: one-cycle rdy_i five cycles after each start_o, plus event recording.
  always @(posedge clk) begin
    #2;
    if (cd > 0) begin
      cd--;
      rdy_auto = (cd == 0);
    end else begin
      rdy_auto = 1'b0;
    end
    if (rdy_auto) last_rdy = cyc;
    if (prep_o) begin
      prep_cnt++;
      prep_cyc = cyc;
    end
    if (first_o) first_cnt++;
    if (start_o) begin
      start_cnt++;
      start_cyc = cyc;
      if (start_cnt == 1) first_on_1 = first_o;
      if (core_auto) cd = 5;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
  end

  task automatic clear_mon();
    prep_cnt = 0; start_cnt = 0; first_cnt = 0; prep_cyc = -1; start_cyc = -1;
    first_mv = -1; last_rdy = -1; first_on_1 = 1'b0;
  endtask

  task automatic set_y(input logic [31:0] hi, input logic [31:0] lo);
    for (int j = 0; j < NY; j++) begin
      lane_exp[j] = {hi, lo | 32'(j)};
      y[(NY-1-j)*SLEN +: SLEN] = lane_exp[j];
    end
  endtask

  task automatic push_expected();
    logic [63:0] lv;
    for (int b = 0; b < NOUT; b++) begin
      lv = lane_exp[b/2];
      sbq.push_back({(b == NOUT-1), 32'h0, ((b % 2) == 0) ? lv[63:32] : lv[31:0]});
    end
  endtask

  function automatic logic [NX*SLEN-1:0] x_model(input logic [31:0] base);
    logic [NX*SLEN-1:0] xe;
    for (int i = 0; i < NX; i++) xe[i*SLEN +: SLEN] = {base + 32'(2*i), base + 32'(2*i+1)};
    return xe;
  endfunction

  task automatic send_block(input logic [31:0] base, input bit last, input int gap,
                            input bit stray_last, input int stray_rdy_word, output int t_acc);
    t_acc = -1;
    for (int k = 0; k < NIN; k++) begin
      int w;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        s_valid = 1'b0; rdy_man = 1'b0; s_data = 32'hDEAD0000; s_last = 1'b1;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = base + 32'(k);
      s_last  = (k == NIN-1) ? last : stray_last;
      rdy_man = (k == stray_rdy_word);
      w = 0;
      while (!s_ready && w < 200) begin
        @(negedge clk);
        rdy_man = 1'b0;
        w++;
      end
      if (w >= 200) begin
        total++; bad++;
        $display("FAIL send_timeout word=%0d ready=%b required=1", k, s_ready);
      end
      if (k == NIN-1) t_acc = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; rdy_man = 1'b0;
  endtask

  task automatic drain(input int mode, input int exp_beats);
    int beats = 0;
    bit stalled = 1'b0;
    logic [31:0] pd;
    logic pl;
    logic [64:0] e;
    for (int n = 0; n < 400 && beats < exp_beats; n++) begin
      @(negedge clk);
      if (stalled && m_valid) begin
        total++;
        if (m_data !== pd || m_last !== pl) begin
          bad++;
          $display("FAIL stall_hold data=%h last=%b required data=%h last=%b", m_data, m_last, pd, pl);
        end
      end
      m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      if (m_valid && m_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL beat_extra data=%h required none", m_data);
        end else begin
          e = sbq.pop_front();
          if ({m_last, 32'h0, m_data} !== e) begin
            bad++;
            $display("FAIL beat%0d last=%b data=%h required last=%b data=%h",
                     beats, m_last, m_data, e[64], e[31:0]);
          end
        end
        beats++;
      end
      stalled = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
    end
    total++;
    if (beats != exp_beats || sbq.size() != 0) begin
      bad++;
      $display("FAIL beat_count got=%0d required=%0d left=%0d", beats, exp_beats, sbq.size());
    end
    @(negedge clk);
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_out m_valid=%b busy=%b required 0 0", m_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b required=0", s_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b required=1", s_ready); end
    total++;
    if ({m_valid, m_last, prep_o, start_o, first_o, busy} !== 6'b0 || m_data !== '0 || x_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs flags=%b data=%h x_nonzero=%b required 0", 
               {m_valid, m_last, prep_o, start_o, first_o, busy}, m_data, |x_o);
    end
  endtask

  task automatic test_single();
    int t;
    clear_mon(); core_auto = 1'b1;
    set_y(32'hAAAA0000, 32'hBBBB0000);
    send_block(32'h0, 1'b1, 1, 1'b0, -1, t);
    repeat (2) @(negedge clk);
    total++;
    if (x_o[63:0] !== 64'h00000000_00000001) begin bad++; $display("FAIL x_lane0 got=%h required=0000000000000001", x_o[63:0]); end
    total++;
    if (x_o !== x_model(32'h0)) begin bad++; $display("FAIL x_pack lane15=%h required=%h", x_o[1023:960], x_model(32'h0) >> 960); end
    total++;
    if (prep_cyc != t+1 || prep_cnt != 1) begin bad++; $display("FAIL prep_timing cyc=%0d cnt=%0d required cyc=%0d cnt=1", prep_cyc, prep_cnt, t+1); end
    total++;
    if (start_cyc != t+2 || first_on_1 !== 1'b1) begin bad++; $display("FAIL start_timing cyc=%0d first=%b required cyc=%0d first=1", start_cyc, first_on_1, t+2); end
    push_expected();
    drain(0, NOUT);
    total++;
    if (first_mv != start_cyc+6) begin bad++; $display("FAIL out_latency got=%0d required=%0d", first_mv, start_cyc+6); end
    total++;
    if (x_o !== x_model(32'h0)) begin bad++; $display("FAIL x_hold got_lane0=%h required=%h", x_o[63:0], 64'h1); end
  endtask

  task automatic test_two_block();
    int t1, t2;
    clear_mon(); core_auto = 1'b1;
    set_y(32'h12340000, 32'h00005600);
    send_block(32'h100, 1'b0, 1, 1'b1, -1, t1);
    send_block(32'h200, 1'b1, 1, 1'b0, -1, t2);
    repeat (2) @(negedge clk);
    total++;
    if (prep_cnt != 1 || first_cnt != 1 || first_on_1 !== 1'b1 || start_cnt != 2) begin
      bad++;
      $display("FAIL two_block_seq prep=%0d first=%0d first_on_1=%b starts=%0d required 1 1 1 2",
               prep_cnt, first_cnt, first_on_1, start_cnt);
    end
    total++;
    if (start_cyc != t2+1) begin bad++; $display("FAIL later_start got=%0d required=%0d", start_cyc, t2+1); end
    total++;
    if (first_mv >= 0) begin bad++; $display("FAIL early_m_valid got=%0d required none", first_mv); end
    total++;
    if (x_o !== x_model(32'h200)) begin bad++; $display("FAIL x_block2 lane0=%h required=%h", x_o[63:0], {32'h200, 32'h201}); end
    push_expected();
    drain(0, NOUT);
    total++;
    if (first_mv != last_rdy+1) begin bad++; $display("FAIL out_after_rdy got=%0d required=%0d", first_mv, last_rdy+1); end
  endtask

  task automatic test_backpressure();
    int t;
    clear_mon(); core_auto = 1'b1;
    set_y(32'h5A5A0000, 32'hC3C30010);
    send_block(32'h40, 1'b1, 1, 1'b0, -1, t);
    push_expected();
    drain(1, NOUT);
  endtask

  task automatic test_gaps_stray_rdy();
    int t;
    clear_mon(); core_auto = 1'b1;
    set_y(32'hAAAA0000, 32'hBBBB0000);
    send_block(32'h0, 1'b1, 3, 1'b0, 5, t);
    @(negedge clk);
    total++;
    if (start_o !== 1'b1) begin bad++; $display("FAIL gap_start got=%b required=1", start_o); end
    rdy_man = 1'b1;
    @(negedge clk);
    rdy_man = 1'b0;
    total++;
    if (x_o !== x_model(32'h0) || prep_cyc != t+1) begin
      bad++;
      $display("FAIL gap_pack lane0=%h prep=%0d required=%h %0d", x_o[63:0], prep_cyc, 64'h1, t+1);
    end
    push_expected();
    drain(0, NOUT);
    total++;
    if (first_mv != start_cyc+6) begin bad++; $display("FAIL stray_rdy got=%0d required=%0d", first_mv, start_cyc+6); end
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen;
    clear_mon(); core_auto = 1'b0;
    set_y(32'h0F0F0000, 32'h00F00000);
    send_block(32'h300, 1'b1, 1, 1'b0, -1, t);
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL wait_state busy=%b ready=%b required 1 0", busy, s_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdy_man = 1'b1;
    @(negedge clk);
    rdy_man = 1'b0;
    total++;
    if ({m_valid, m_last, prep_o, start_o, first_o, busy} !== 6'b0 || m_data !== '0 || x_o !== '0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset flags=%b data=%h ready=%b required 0 0 1",
               {m_valid, m_last, prep_o, start_o, first_o, busy}, m_data, s_ready);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid || busy) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL rdy_after_reset activity=1 required=0"); end
    clear_mon(); core_auto = 1'b1;
    send_block(32'h400, 1'b1, 1, 1'b0, -1, t);
    repeat (2) @(negedge clk);
    total++;
    if (prep_cnt != 1 || first_cnt != 1) begin bad++; $display("FAIL prep_again prep=%0d first=%0d required 1 1", prep_cnt, first_cnt); end
    push_expected();
    drain(0, NOUT);
  endtask

  task automatic test_wpl1();
    logic [16*64-1:0] xe;
    logic [63:0] lanes[8];
    logic [64:0] e;
    int w, beats;
    for (int j = 0; j < 8; j++) begin
      lanes[j] = 64'hC0DE0000_00000000 | 64'(j);
      y64[(7-j)*64 +: 64] = lanes[j];
      sbq.push_back({(j == 7), lanes[j]});
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s_valid64 = 1'b1;
      s_data64  = {32'h11110000, 32'(k)};
      s_last64  = (k == 15);
      xe[k*64 +: 64] = s_data64;
      w = 0;
      while (!s_ready64 && w < 100) begin @(negedge clk); w++; end
    end
    @(negedge clk);
    s_valid64 = 1'b0; s_last64 = 1'b0;
    total++;
    if (x64 !== xe) begin bad++; $display("FAIL wpl1_pack lane0=%h lane15=%h required=%h %h", x64[63:0], x64[1023:960], xe[63:0], xe[1023:960]); end
    w = 0;
    while (!start64 && w < 20) begin @(negedge clk); w++; end
    total++;
    if (!start64) begin bad++; $display("FAIL wpl1_start got=0 required=1"); end
    @(negedge clk);
    rdy64 = 1'b1;
    @(negedge clk);
    rdy64 = 1'b0;
    m_ready64 = 1'b1;
    beats = 0;
    for (int n = 0; n < 50 && beats < 8; n++) begin
      if (m_valid64) begin
        e = sbq.pop_front();
        total++;
        if ({m_last64, m_data64} !== e) begin
          bad++;
          $display("FAIL wpl1_beat%0d last=%b data=%h required last=%b data=%h", beats, m_last64, m_data64, e[64], e[63:0]);
        end
        beats++;
      end
      @(negedge clk);
    end
    m_ready64 = 1'b0;
    total++;
    if (beats != 8 || m_valid64 !== 1'b0) begin bad++; $display("FAIL wpl1_count got=%0d valid=%b required=8 0", beats, m_valid64); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0; y = '0;
    s_valid64 = 1'b0; s_data64 = '0; s_last64 = 1'b0; m_ready64 = 1'b0; rdy64 = 1'b0; y64 = '0;
    rdy_man = 1'b0; rdy_auto = 1'b0; cd = 0; core_auto = 1'b1;
    clear_mon();
    test_reset();
    test_single();
    test_two_block();
    test_backpressure();
    test_gaps_stray_rdy();
    test_reset_mid();
    test_wpl1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
